json_cmd_rx: RTL and testbench

//  UART receiver and line parser for motion-command JSON, e.g. {"T":1,"L":-0.25,"R":0.25}\n.

---
 rtl/json_cmd_rx.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_json_cmd_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/json_cmd_rx.sv
// json_cmd_rx: 8N1 UART receiver plus line parser for motion-command JSON such as
// {"T":1,"L":-0.25,"R":0.25}\n. Each good line yields one command (T, L, R) on a
// valid/ready port. L and R are carried in thousandths.
// Optional build macro JSON_CMD_RX_STATS_EN adds cmd_count/err_count statistics outputs.
module json_cmd_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_LEN      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_in,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [7:0]  cmd_t,
  output logic [15:0] cmd_l,
  output logic [15:0] cmd_r,
  output logic        err_frame,
  output logic        err_parse,
`ifdef JSON_CMD_RX_STATS_EN
  output logic [15:0] cmd_count,
  output logic [15:0] err_count,
`endif
  output logic        cmd_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int LW = $clog2(MAX_LEN + 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] NL = 8'h0A;
  localparam logic [1:0] K_T = 2'd0, K_L = 2'd1, K_R = 2'd2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_e;
  typedef enum logic [3:0] {
    P_WAIT_OPEN, P_KEY_Q1, P_KEY, P_KEY_Q2, P_COLON, P_VAL_SIGN,
    P_VAL_INT, P_VAL_FRAC, P_AFTER_VAL, P_WAIT_NL, P_FLUSH
  } pState_e;

  // ---------------- UART receive ----------------
  logic sync1_q, sync2_q, lineHigh_q;
  logic [1:0] settle_q;
  rxState_e rxState_q, rxState_d;
  logic [CW-1:0] rxCnt_q, rxCnt_d;
  logic [2:0] bitIdx_q, bitIdx_d;
  logic [7:0] shift_q, shift_d;
  logic byteStb_q, byteStb_d, frameErr_q, frameErr_d;

  // Synchroniser and "line seen high" tracker; settle_q hides the synchroniser's reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      settle_q   <= 2'b00;
      lineHigh_q <= 1'b0;
    end else begin
      sync1_q    <= uart_in;
      sync2_q    <= sync1_q;
      settle_q   <= {settle_q[0], 1'b1};
      lineHigh_q <= settle_q[1] & sync2_q;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxState_q  <= RX_IDLE;
      rxCnt_q    <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      byteStb_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      rxState_q  <= rxState_d;
      rxCnt_q    <= rxCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      byteStb_q  <= byteStb_d;
      frameErr_q <= frameErr_d;
    end
  end

  // Receiver next state: centre-sample start, 8 data bits LSB first, then the stop bit
  always_comb begin
    rxState_d  = rxState_q;
    rxCnt_d    = rxCnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    byteStb_d  = 1'b0;
    frameErr_d = 1'b0;
    case (rxState_q)
      RX_IDLE: begin
        rxCnt_d  = '0;
        bitIdx_d = '0;
        if (lineHigh_q && !sync2_q) rxState_d = RX_START;
      end
      RX_START: begin
        rxCnt_d = rxCnt_q + 1'b1;
        if (rxCnt_q == HALF_LAST) begin
          rxCnt_d   = '0;
          rxState_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        rxCnt_d = rxCnt_q + 1'b1;
        if (rxCnt_q == BIT_LAST) begin
          rxCnt_d  = '0;
          shift_d  = {sync2_q, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 1'b1;
          if (bitIdx_q == 3'd7) rxState_d = RX_STOP;
        end
      end
      RX_STOP: begin
        rxCnt_d = rxCnt_q + 1'b1;
        if (rxCnt_q == BIT_LAST) begin
          rxCnt_d    = '0;
          rxState_d  = RX_IDLE;
          byteStb_d  = sync2_q;
          frameErr_d = !sync2_q;
        end
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

  // ---------------- Line parser ----------------
  pState_e pState_q, pState_d;
  logic [1:0] key_q, key_d;
  logic [2:0] seen_q, seen_d;
  logic neg_q, neg_d, intSeen_q, intSeen_d;
  logic [3:0] intVal_q, intVal_d;
  logic [9:0] frac_q, frac_d;
  logic [1:0] fracCnt_q, fracCnt_d;
  logic [7:0] tAcc_q, tAcc_d, tVal_q, tVal_d;
  logic [15:0] lVal_q, lVal_d, rVal_q, rVal_d;
  logic [LW-1:0] len_q, len_d;
  logic cmdDone, parseErr, fail, doInt, doEnd;

  logic [7:0] rxByte;
  logic isDigit, isSpace;
  logic [3:0] digit;
  logic [11:0] tNext;
  logic [9:0] fracAdd;
  logic [15:0] mag, sVal;

  assign rxByte  = shift_q;
  assign isDigit = (rxByte >= 8'h30) && (rxByte <= 8'h39);
  assign isSpace = (rxByte == 8'h20);
  assign digit   = rxByte[3:0];
  assign tNext   = 12'(tAcc_q) * 12'd10 + 12'(digit);
  assign fracAdd = (fracCnt_q == 2'd0) ? 10'(digit) * 10'd100 :
                   (fracCnt_q == 2'd1) ? 10'(digit) * 10'd10 : 10'(digit);
  assign mag     = 16'(intVal_q) * 16'd1000 + 16'(frac_q);
  assign sVal    = neg_q ? (16'd0 - mag) : mag;

  // Parser state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pState_q <= P_WAIT_OPEN;
      key_q <= '0; seen_q <= '0; neg_q <= 1'b0; intSeen_q <= 1'b0;
      intVal_q <= '0; frac_q <= '0; fracCnt_q <= '0; tAcc_q <= '0;
      tVal_q <= '0; lVal_q <= '0; rVal_q <= '0; len_q <= '0;
    end else begin
      pState_q <= pState_d;
      key_q <= key_d; seen_q <= seen_d; neg_q <= neg_d; intSeen_q <= intSeen_d;
      intVal_q <= intVal_d; frac_q <= frac_d; fracCnt_q <= fracCnt_d; tAcc_q <= tAcc_d;
      tVal_q <= tVal_d; lVal_q <= lVal_d; rVal_q <= rVal_d; len_q <= len_d;
    end
  end

  // Parser next state: one byte per strobe; a malformed byte that is itself '\n' already ends the line
  always_comb begin
    pState_d = pState_q; key_d = key_q; seen_d = seen_q; neg_d = neg_q;
    intSeen_d = intSeen_q; intVal_d = intVal_q; frac_d = frac_q; fracCnt_d = fracCnt_q;
    tAcc_d = tAcc_q; tVal_d = tVal_q; lVal_d = lVal_q; rVal_d = rVal_q; len_d = len_q;
    cmdDone = 1'b0; parseErr = 1'b0; fail = 1'b0; doInt = 1'b0; doEnd = 1'b0;
    if (frameErr_q) begin
      pState_d = P_FLUSH;
    end else if (byteStb_q) begin
      if (pState_q != P_WAIT_OPEN && pState_q != P_FLUSH) begin
        len_d = len_q + 1'b1;
        if (len_q >= LW'(MAX_LEN)) fail = 1'b1;
      end
      if (!fail) begin
        case (pState_q)
          P_WAIT_OPEN: if (rxByte == "{") begin
            pState_d = P_KEY_Q1; seen_d = '0; len_d = LW'(1);
          end
          P_FLUSH: if (rxByte == NL) pState_d = P_WAIT_OPEN;
          P_KEY_Q1: if (!isSpace) begin
            if (rxByte == "\"") pState_d = P_KEY; else fail = 1'b1;
          end
          P_KEY: if (!isSpace) begin
            if (rxByte == "T" && !seen_q[0])      begin key_d = K_T; pState_d = P_KEY_Q2; end
            else if (rxByte == "L" && !seen_q[1]) begin key_d = K_L; pState_d = P_KEY_Q2; end
            else if (rxByte == "R" && !seen_q[2]) begin key_d = K_R; pState_d = P_KEY_Q2; end
            else fail = 1'b1;
          end
          P_KEY_Q2: if (!isSpace) begin
            if (rxByte == "\"") pState_d = P_COLON; else fail = 1'b1;
          end
          P_COLON: if (!isSpace) begin
            if (rxByte == ":") begin
              pState_d = P_VAL_SIGN; neg_d = 1'b0; intSeen_d = 1'b0;
              intVal_d = '0; frac_d = '0; fracCnt_d = '0; tAcc_d = '0;
            end else fail = 1'b1;
          end
          P_VAL_SIGN: if (!isSpace) begin
            if (rxByte == "-" && key_q != K_T) begin neg_d = 1'b1; pState_d = P_VAL_INT; end
            else if (isDigit) begin doInt = 1'b1; pState_d = P_VAL_INT; end
            else fail = 1'b1;
          end
          P_VAL_INT: begin
            if (isDigit) doInt = 1'b1;
            else if (rxByte == "." && key_q != K_T && intSeen_q) pState_d = P_VAL_FRAC;
            else if (intSeen_q && (isSpace || rxByte == "," || rxByte == "}")) doEnd = 1'b1;
            else fail = 1'b1;
          end
          P_VAL_FRAC: begin
            if (isDigit) begin
              if (fracCnt_q != 2'd3) begin
                frac_d = frac_q + fracAdd; fracCnt_d = fracCnt_q + 1'b1;
              end
            end else if (isSpace || rxByte == "," || rxByte == "}") doEnd = 1'b1;
            else fail = 1'b1;
          end
          P_AFTER_VAL: if (!isSpace) begin
            if (rxByte == ",") pState_d = P_KEY_Q1;
            else if (rxByte == "}") pState_d = P_WAIT_NL;
            else fail = 1'b1;
          end
          P_WAIT_NL: if (!isSpace) begin
            if (rxByte == NL && (&seen_q)) begin cmdDone = 1'b1; pState_d = P_WAIT_OPEN; end
            else fail = 1'b1;
          end
          default: pState_d = P_WAIT_OPEN;
        endcase
      end
      if (doInt) begin
        intSeen_d = 1'b1;
        if (key_q == K_T) tAcc_d = (tNext > 12'd255) ? 8'd255 : tNext[7:0];
        else if (intSeen_q) fail = 1'b1;
        else intVal_d = digit;
      end
      if (doEnd) begin
        seen_d[key_q] = 1'b1;
        if (key_q == K_T) tVal_d = tAcc_q;
        else if (key_q == K_L) lVal_d = sVal;
        else rVal_d = sVal;
        pState_d = isSpace ? P_AFTER_VAL : (rxByte == ",") ? P_KEY_Q1 : P_WAIT_NL;
      end
      if (fail) begin
        parseErr = 1'b1;
        pState_d = (rxByte == NL) ? P_WAIT_OPEN : P_FLUSH;
      end
    end
  end

  // ---------------- Output port ----------------
  logic cmdValid_q, errParse_q, overrun_q;
  logic [7:0] cmdT_q;
  logic [15:0] cmdL_q, cmdR_q;

  // Load a completed command when the slot is free or draining this cycle, otherwise drop it and flag overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmdValid_q <= 1'b0; cmdT_q <= '0; cmdL_q <= '0; cmdR_q <= '0;
      errParse_q <= 1'b0; overrun_q <= 1'b0;
    end else begin
      errParse_q <= parseErr;
      overrun_q  <= 1'b0;
      if (cmdDone && (!cmdValid_q || cmd_ready)) begin
        cmdValid_q <= 1'b1;
        cmdT_q <= tVal_q; cmdL_q <= lVal_q; cmdR_q <= rVal_q;
      end else begin
        if (cmdDone) overrun_q <= 1'b1;
        if (cmdValid_q && cmd_ready) cmdValid_q <= 1'b0;
      end
    end
  end

  assign cmd_valid   = cmdValid_q;
  assign cmd_t       = cmdT_q;
  assign cmd_l       = cmdL_q;
  assign cmd_r       = cmdR_q;
  assign err_frame   = frameErr_q;
  assign err_parse   = errParse_q;
  assign cmd_overrun = overrun_q;

`ifdef JSON_CMD_RX_STATS_EN
  logic [15:0] cmdCount_q, errCount_q;

  // Free-running wrap-around counters of completed commands and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmdCount_q <= '0;
      errCount_q <= '0;
    end else begin
      if (cmdDone) cmdCount_q <= cmdCount_q + 16'd1;
      errCount_q <= errCount_q + 16'(frameErr_q) + 16'(errParse_q);
    end
  end

  assign cmd_count = cmdCount_q;
  assign err_count = errCount_q;
`endif

endmodule

// File: tb/tb_json_cmd_rx.sv
// tb_json_cmd_rx: table of JSON lines with hand-computed decodes, plus sequences for
// back-pressure/overrun, stop-bit framing errors and a reset in the middle of a byte.
module tb_json_cmd_rx;

  localparam int CPB  = 8;
  localparam int MAXL = 32;

  logic clk = 1'b0;
  logic rst_n, uart_in, cmd_ready;
  logic cmd_valid, err_frame, err_parse, cmd_overrun;
  logic [7:0] cmd_t;
  logic [15:0] cmd_l, cmd_r;

  json_cmd_rx #(.CLKS_PER_BIT(CPB), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst_n(rst_n), .uart_in(uart_in), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_t(cmd_t), .cmd_l(cmd_l), .cmd_r(cmd_r),
    .err_frame(err_frame), .err_parse(err_parse), .cmd_overrun(cmd_overrun)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int nXfer = 0, nFrame = 0, nParse = 0, nOver = 0;
  logic [7:0] lastT = '0;
  logic [15:0] lastL = '0, lastR = '0;

  // Count handshakes and error pulses, remembering the last transferred command
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        nXfer <= nXfer + 1; lastT <= cmd_t; lastL <= cmd_l; lastR <= cmd_r;
      end
      if (err_frame)   nFrame <= nFrame + 1;
      if (err_parse)   nParse <= nParse + 1;
      if (cmd_overrun) nOver  <= nOver + 1;
    end
  end

  typedef struct {
    string line;
    int    cmds;
    int    t;
    int    l;
    int    r;
    int    perr;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [15:0] s16(input int x);
    return x[15:0];
  endfunction

  task automatic addVec(input string line, input int cmds, input int t, input int l, input int r, input int perr);
    vec_t v;
    v.line = line; v.cmds = cmds; v.t = t; v.l = l; v.r = r; v.perr = perr;
    vecs.push_back(v);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    uart_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      tick(CPB);
    end
    uart_in = stopBit;
    tick(CPB);
    uart_in = 1'b1;
  endtask

  task automatic applyStimulus(input string s);
    for (int i = 0; i < s.len(); i++) sendByte(s[i], 1'b1);
    tick(2 * CPB);
  endtask

  task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    int bX, bF, bP, bO;
    rst_n = 1'b0; uart_in = 1'b1; cmd_ready = 1'b1;

    addVec("{\"T\":1,\"L\":0.5,\"R\":0.5}\n",              1, 1,   500,   500,  0);
    addVec("{\"T\":1,\"L\":-0.25,\"R\":0.25}\n",           1, 1,  -250,   250,  0);
    addVec("{\"T\":1,\"L\":-0.5,\"R\":-0.5}\n",            1, 1,  -500,  -500,  0);
    addVec("{\"T\":300,\"R\":9.999,\"L\":-9.999}\n",       1, 255, -9999, 9999, 0);
    addVec("{\"T\":1,\"L\":0.5}\n",                        0, 0,     0,     0,  1);
    addVec("{\"T\":1,\"L\":0.5000000000000000,\"R\":0.5}\n", 0, 0,   0,     0,  1);
    addVec("{\"T\":255,\"L\":-1.2500,\"R\":0.75 }\n",      1, 255, -1250,  750,  0);
    addVec("{\"T\":255,\"L\":-1.2500,\"R\":0.75  }\n",     0, 0,     0,     0,  1);
    addVec("{\"T\": 7 ,\"L\":1.23456,\"R\": 0}\n",         1, 7,  1234,     0,  0);
    addVec("{\"T\":1,\"T\":2,\"L\":0,\"R\":0}\n",          0, 0,     0,     0,  1);
    addVec("{\"X\":1}\n",                                  0, 0,     0,     0,  1);
    addVec("{\"T\":1,\"L\":12,\"R\":0}\n",                 0, 0,     0,     0,  1);
    addVec("xx{\"T\":2,\"L\":0.001,\"R\":-0.010}\n",       1, 2,     1,   -10,  0);
    addVec("{\"T\":-1,\"L\":0,\"R\":0}\n",                 0, 0,     0,     0,  1);

    // Reset state
    tick(3);
    checkOutput("reset_valid", 48'(cmd_valid), 48'd0);
    checkOutput("reset_errs", 48'({err_frame, err_parse, cmd_overrun}), 48'd0);
    checkOutput("reset_data", {8'd0, cmd_t, cmd_l, cmd_r}, 48'd0);
    rst_n = 1'b1;
    tick(4 * CPB);
    checkOutput("post_reset_valid", 48'(cmd_valid), 48'd0);

    // Table of lines with cmd_ready held high
    foreach (vecs[i]) begin
      bX = nXfer; bF = nFrame; bP = nParse; bO = nOver;
      applyStimulus(vecs[i].line);
      checkOutput($sformatf("v%0d_cmds", i), 48'(nXfer - bX), 48'(vecs[i].cmds));
      checkOutput($sformatf("v%0d_perr", i), 48'(nParse - bP), 48'(vecs[i].perr));
      checkOutput($sformatf("v%0d_ferr", i), 48'(nFrame - bF), 48'd0);
      checkOutput($sformatf("v%0d_ovr", i), 48'(nOver - bO), 48'd0);
      if (vecs[i].cmds == 1) begin
        checkOutput($sformatf("v%0d_t", i), 48'(lastT), 48'(vecs[i].t[7:0]));
        checkOutput($sformatf("v%0d_l", i), 48'(lastL), 48'(s16(vecs[i].l)));
        checkOutput($sformatf("v%0d_r", i), 48'(lastR), 48'(s16(vecs[i].r)));
      end
    end
    checkOutput("idle_valid", 48'(cmd_valid), 48'd0);

    // Back-pressure: first command held, second dropped with one overrun pulse
    cmd_ready = 1'b0;
    bX = nXfer; bO = nOver;
    applyStimulus("{\"T\":3,\"L\":0.1,\"R\":0.2}\n");
    checkOutput("bp_valid1", 48'(cmd_valid), 48'd1);
    applyStimulus("{\"T\":4,\"L\":0.3,\"R\":0.4}\n");
    checkOutput("bp_valid2", 48'(cmd_valid), 48'd1);
    checkOutput("bp_held", {8'd0, cmd_t, cmd_l, cmd_r}, {8'd0, 8'd3, s16(100), s16(200)});
    checkOutput("bp_overrun", 48'(nOver - bO), 48'd1);
    checkOutput("bp_noxfer", 48'(nXfer - bX), 48'd0);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    tick(1);
    checkOutput("bp_drained", 48'(cmd_valid), 48'd0);
    checkOutput("bp_xfer", 48'(nXfer - bX), 48'd1);
    checkOutput("bp_xfer_data", {8'd0, lastT, lastL, lastR}, {8'd0, 8'd3, s16(100), s16(200)});
    cmd_ready = 1'b1;

    // Stop bit low inside a line, then the line is finished and a good one follows
    bX = nXfer; bF = nFrame; bP = nParse;
    applyStimulus("{\"T\":1,");
    sendByte(8'h22, 1'b0);
    tick(2 * CPB);
    applyStimulus("\n");
    checkOutput("fe_frame", 48'(nFrame - bF), 48'd1);
    checkOutput("fe_nocmd", 48'(nXfer - bX), 48'd0);
    applyStimulus("{\"T\":5,\"L\":0.5,\"R\":-0.5}\n");
    checkOutput("fe_parse", 48'(nParse - bP), 48'd0);
    checkOutput("fe_cmd", 48'(nXfer - bX), 48'd1);
    checkOutput("fe_data", {8'd0, lastT, lastL, lastR}, {8'd0, 8'd5, s16(500), s16(-500)});

    // Reset while a command is held and a byte is mid-flight
    cmd_ready = 1'b0;
    applyStimulus("{\"T\":9,\"L\":0.9,\"R\":-0.9}\n");
    checkOutput("mr_held", 48'(cmd_valid), 48'd1);
    uart_in = 1'b0;
    tick(3 * CPB + CPB / 2);
    rst_n = 1'b0;
    tick(1);
    checkOutput("mr_valid", 48'(cmd_valid), 48'd0);
    checkOutput("mr_data", {8'd0, cmd_t, cmd_l, cmd_r}, 48'd0);
    tick(2);
    checkOutput("mr_errs", 48'({err_frame, err_parse, cmd_overrun}), 48'd0);
    rst_n = 1'b1;
    tick(3 * CPB);
    uart_in = 1'b1;
    tick(2 * CPB);
    cmd_ready = 1'b1;
    bX = nXfer; bF = nFrame; bP = nParse; bO = nOver;
    applyStimulus("{\"T\":2,\"L\":0.002,\"R\":0.02}\n");
    checkOutput("mr_cmd", 48'(nXfer - bX), 48'd1);
    checkOutput("mr_noerr", 48'((nFrame - bF) + (nParse - bP) + (nOver - bO)), 48'd0);
    checkOutput("mr_out", {8'd0, lastT, lastL, lastR}, {8'd0, 8'd2, s16(2), s16(20)});

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
